// File: rtl/sphere3_mon_pkg.sv
// Shared point type, Q-format constants and saturating-increment helpers
// for the sphere3 stream monitor.
package sphere3_mon_pkg;

  localparam int FRAC_IN  = 31;
  localparam int FRAC_R2  = 28;
  localparam int R2_SHIFT = 2 * FRAC_IN - FRAC_R2;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] w;
    logic [31:0] r2;
    logic [3:0]  orthant;
    logic        err;
  } point_t;

  function automatic logic [63:0] square(input logic [31:0] v);
    logic signed [63:0] sv;
    sv = {{32{v[31]}}, v};
    return sv * sv;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) begin
      return v + 16'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/sphere3_mon_fifo.sv
// First-word-fall-through FIFO of tagged points; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module sphere3_mon_fifo
  import sphere3_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  point_t push_data_i,
  input  logic   pop_i,
  output point_t head_o,
  output logic   valid_o,
  output logic   full_o,
  output logic   drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  point_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          pop_s;
  logic          push_s;

  always_comb begin
    valid_o = (count_q != {(AW+1){1'b0}});
    full_o  = (count_q == CNT_MAX);
    pop_s   = pop_i && valid_o;
    push_s  = push_i && (!full_o || pop_s);
    drop_o  = push_i && full_o && !pop_s;
    head_o  = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sphere3_stream_monitor.sv
// Three-stage r^2 / orthant tagger feeding an FWFT FIFO, with point, error
// and drop counters. Define SPHERE3_MON_HIST_EN to add per-orthant histograms.
module sphere3_stream_monitor
  import sphere3_mon_pkg::*;
#(
  parameter int          DEPTH = 4,
  parameter logic [31:0] R2_LO = 32'd214748365,
  parameter logic [31:0] R2_HI = 32'd322122547
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic [31:0] in_z,
  input  logic [31:0] in_w,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_z,
  output logic [31:0] out_w,
  output logic [31:0] out_r2,
  output logic [3:0]  out_orthant,
  output logic        out_r2_err,
  output logic        full,
  input  logic        cnt_clr,
  output logic [31:0] pt_count,
  output logic [31:0] err_count,
  output logic [31:0] drop_count
`ifdef SPHERE3_MON_HIST_EN
  ,
  input  logic [3:0]  hist_sel,
  output logic [15:0] hist_count
`endif
);

  logic        s1_valid_q;
  logic [31:0] s1_x_q, s1_y_q, s1_z_q, s1_w_q;
  logic [63:0] s1_xx_q, s1_yy_q, s1_zz_q, s1_ww_q;
  logic        s2_valid_q;
  logic [31:0] s2_x_q, s2_y_q, s2_z_q, s2_w_q;
  logic [64:0] s2_xy_q, s2_zw_q;
  logic [65:0] total_s;
  point_t      s3_pt_s;
  point_t      head_s;
  logic        drop_s;
  logic [31:0] pt_count_q, pt_count_d;
  logic [31:0] err_count_q, err_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  // S1 squares and S2 pairwise sums; the FIFO entry itself is the S3 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= 32'd0;
      s1_y_q     <= 32'd0;
      s1_z_q     <= 32'd0;
      s1_w_q     <= 32'd0;
      s1_xx_q    <= 64'd0;
      s1_yy_q    <= 64'd0;
      s1_zz_q    <= 64'd0;
      s1_ww_q    <= 64'd0;
      s2_valid_q <= 1'b0;
      s2_x_q     <= 32'd0;
      s2_y_q     <= 32'd0;
      s2_z_q     <= 32'd0;
      s2_w_q     <= 32'd0;
      s2_xy_q    <= 65'd0;
      s2_zw_q    <= 65'd0;
    end else begin
      s1_valid_q <= in_valid;
      s1_x_q     <= in_x;
      s1_y_q     <= in_y;
      s1_z_q     <= in_z;
      s1_w_q     <= in_w;
      s1_xx_q    <= square(in_x);
      s1_yy_q    <= square(in_y);
      s1_zz_q    <= square(in_z);
      s1_ww_q    <= square(in_w);
      s2_valid_q <= s1_valid_q;
      s2_x_q     <= s1_x_q;
      s2_y_q     <= s1_y_q;
      s2_z_q     <= s1_z_q;
      s2_w_q     <= s1_w_q;
      s2_xy_q    <= {1'b0, s1_xx_q} + {1'b0, s1_yy_q};
      s2_zw_q    <= {1'b0, s1_zz_q} + {1'b0, s1_ww_q};
    end
  end

  always_comb begin
    total_s         = {1'b0, s2_xy_q} + {1'b0, s2_zw_q};
    s3_pt_s.x       = s2_x_q;
    s3_pt_s.y       = s2_y_q;
    s3_pt_s.z       = s2_z_q;
    s3_pt_s.w       = s2_w_q;
    s3_pt_s.r2      = 32'(total_s >> R2_SHIFT);
    s3_pt_s.orthant = {s2_w_q[FRAC_IN], s2_z_q[FRAC_IN], s2_y_q[FRAC_IN], s2_x_q[FRAC_IN]};
    s3_pt_s.err     = (s3_pt_s.r2 < R2_LO) || (s3_pt_s.r2 > R2_HI);
  end

  sphere3_mon_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (s2_valid_q),
    .push_data_i (s3_pt_s),
    .pop_i       (out_ready),
    .head_o      (head_s),
    .valid_o     (out_valid),
    .full_o      (full),
    .drop_o      (drop_s)
  );

  assign out_x       = head_s.x;
  assign out_y       = head_s.y;
  assign out_z       = head_s.z;
  assign out_w       = head_s.w;
  assign out_r2      = head_s.r2;
  assign out_orthant = head_s.orthant;
  assign out_r2_err  = head_s.err;

  // Counters count every S3 result, dropped or not; clear beats increment.
  always_comb begin
    if (cnt_clr) begin
      pt_count_d   = 32'd0;
      err_count_d  = 32'd0;
      drop_count_d = 32'd0;
    end else begin
      pt_count_d   = sat_inc32(pt_count_q, s2_valid_q);
      err_count_d  = sat_inc32(err_count_q, s2_valid_q && s3_pt_s.err);
      drop_count_d = sat_inc32(drop_count_q, drop_s);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pt_count_q   <= 32'd0;
      err_count_q  <= 32'd0;
      drop_count_q <= 32'd0;
    end else begin
      pt_count_q   <= pt_count_d;
      err_count_q  <= err_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign pt_count   = pt_count_q;
  assign err_count  = err_count_q;
  assign drop_count = drop_count_q;

`ifdef SPHERE3_MON_HIST_EN
  logic [15:0] hist_q [16];
  logic [15:0] hist_count_q;

  // Per-orthant histogram with a registered one-cycle read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        hist_q[i] <= 16'd0;
      end
      hist_count_q <= 16'd0;
    end else begin
      if (cnt_clr) begin
        for (int i = 0; i < 16; i++) begin
          hist_q[i] <= 16'd0;
        end
      end else begin
        hist_q[s3_pt_s.orthant] <= sat_inc16(hist_q[s3_pt_s.orthant], s2_valid_q);
      end
      hist_count_q <= hist_q[hist_sel];
    end
  end

  assign hist_count = hist_count_q;
`endif

endmodule

// File: doc/sphere3_stream_monitor.md
Name: sphere3_stream_monitor

Overview:
- Sits directly downstream of the sphere3_32bit generator and consumes its 4-D points (Q1.31 signed x/y/z/w, single-cycle valid).
- Computes r² in a fixed 3-stage pipeline, flags points outside tolerance and tags each point with its 4-bit orthant.
- Buffers tagged points in a FIFO with a valid/ready output, and keeps point, error and drop counters for system-level sequence checking.

Parameters:
- DEPTH, 4, output FIFO depth in entries, power of two, minimum 2.
- R2_LO, 32'd214748365, lower r² bound in Q4.28 (0.8).
- R2_HI, 32'd322122547, upper r² bound in Q4.28 (1.2).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  point strobe from the generator; no backpressure toward the generator.
- in_x, in_y, in_z, in_w  in  32 each  Q1.31 signed coordinates.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry when high together with out_valid.
- out_x, out_y, out_z, out_w  out  32 each  buffered coordinates.
- out_r2  out  32  Q4.28 unsigned r².
- out_orthant  out  4  sign bits {w,z,y,x}.
- out_r2_err  out  1  r² < R2_LO or r² > R2_HI.
- full  out  1  FIFO holds DEPTH entries.
- cnt_clr  in  1  synchronous clear of all counters.
- pt_count, err_count, drop_count  out  32 each  saturating counters.

Behaviour:
- Reset: every output is 0, the FIFO is empty, pipeline valids are cleared and all counters are 0. A reset asserted mid-burst discards all in-flight and buffered points.
- S1 registers the four signed squares, each 64-bit unsigned.
- S2 registers the pairwise sums x²+y² and z²+w², each 65 bits.
- S3 registers:
  - the total, 66 bits;
  - r2 = total[65:34], truncated, never saturates, maximum 0x40000000;
  - the orthant, {w[31],z[31],y[31],x[31]};
  - the error compare.
- S3 then writes the FIFO. The pipeline never stalls, so a new point is accepted every cycle.
- Latency: in_valid at cycle N gives out_valid at cycle N+3 when the FIFO is empty. The FIFO is first-word-fall-through.
- Pop occurs on out_valid && out_ready.
- Write when full:
  - Without a same-cycle pop, the point is dropped and drop_count increments.
  - With a same-cycle pop, the point is accepted and the occupancy is unchanged.
- Write and pop on an empty FIFO: the entry is stored, becomes visible the next cycle, and the pop is ignored because out_valid=0.
- Pointers wrap modulo DEPTH; occupancy is tracked in log2(DEPTH)+1 bits.
- Counters:
  - pt_count increments on each S3 result, including dropped points.
  - err_count increments when out_r2_err is computed high, including dropped points.
  - All counters saturate at 0xFFFFFFFF.
  - cnt_clr has priority over an increment in the same cycle.

Optional Feature:
- Macro SPHERE3_MON_HIST_EN.
- Defined: adds ports hist_sel (in, 4) and hist_count (out, 16), registered with 1-cycle read latency. There are 16 saturating 16-bit orthant counters, incremented at S3 and cleared by rst and cnt_clr.
- Undefined: the ports and counters are absent.

Decomposition:
- Package sphere3_mon_pkg holds:
  - the point_t struct (x, y, z, w, r2, orthant, err);
  - the Q-format constants FRAC_IN=31 and FRAC_R2=28;
  - the R2 shift constant 34.
- Sub-module sphere3_mon_fifo: parameterised FWFT FIFO of point_t with push, pop, full, empty and drop logic.

Test Plan:
- x=0x7FFFFFFF, y=z=w=0 -> N+3: out_r2=0x0FFFFFFF, orthant=0, err=0, pt_count=1.
- x=0x80000000, others 0 -> out_r2=0x10000000, orthant=4'b0001, err=0.
- All zero -> out_r2=0, err=1, err_count=1; x=y=0x5A827999, z=w=0 -> r2≈0x0FFFFFFF, err=0.
- DEPTH=4, out_ready=0, 6 back-to-back in_valid -> full=1, drop_count=2, pt_count=6; then out_ready=1 -> 4 pops in order.
- Full FIFO with in_valid and out_ready in the same cycle -> drop_count unchanged, occupancy stays 4.
- Reset asserted 2 cycles into a 5-point burst -> out_valid=0 and counters=0; the next point appears 3 cycles after its in_valid.
